// File: rtl/collision_probe_scanner.sv
// rtl/collision_probe_scanner.sv - four-point collision ROM probe scanner for NUM_CHARS characters
module collision_probe_scanner #(
  parameter int NUM_CHARS   = 2,
  parameter int ROM_LATENCY = 3,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int DATA_W      = 3,
  parameter int CONTINUOUS  = 0
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [NUM_CHARS*10-1:0]       char_left,
  input  logic [NUM_CHARS*10-1:0]       char_right,
  input  logic [NUM_CHARS*10-1:0]       char_top,
  input  logic [NUM_CHARS*10-1:0]       char_bottom,
  input  logic [NUM_CHARS*10-1:0]       side_dy,
  input  logic [NUM_CHARS*10-1:0]       mid_dx,
  output logic [18:0]                   rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic [NUM_CHARS*DATA_W-1:0]   hit_left,
  output logic [NUM_CHARS*DATA_W-1:0]   hit_right,
  output logic [NUM_CHARS*DATA_W-1:0]   hit_top,
  output logic [NUM_CHARS*DATA_W-1:0]   hit_bottom,
  output logic                          busy,
  output logic                          scan_done
);

  localparam int P  = 4 * NUM_CHARS;
  localparam int CW = $clog2(P + ROM_LATENCY + 2);
  localparam int PW = $clog2(P);
  localparam logic [10:0] XMAX = 11'(SCREEN_W - 1);
  localparam logic [9:0]  YMAX = 10'(SCREEN_H - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          go, issue, publish, relatch;

  logic [NUM_CHARS*10-1:0] l_left, l_right, l_top, l_bottom, l_dy, l_dx;
  logic [9:0]  s_left, s_right, s_top, s_bottom, s_dy, s_dx;
  logic [9:0]  xl, xr, xm, ys, yt, yb, x, y;
  logic [18:0] addr_w;

  logic              tag_v [ROM_LATENCY];
  logic [PW-1:0]     tag_p [ROM_LATENCY];
  logic [DATA_W-1:0] shadow [P];

  function automatic logic [9:0] clamp_x(input logic [10:0] v);
    return (v > XMAX) ? XMAX[9:0] : v[9:0];
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] v);
    return (v > YMAX) ? YMAX : v;
  endfunction

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = (state == S_IDLE) && (start || (CONTINUOUS != 0));
    issue    = (state == S_SCAN) && (cnt < CW'(P));
    publish  = (state == S_SCAN) && (cnt == CW'(P + ROM_LATENCY));
    relatch  = go || (publish && (CONTINUOUS != 0));
    busy     = (state == S_SCAN);
    case (state)
      S_IDLE: if (go) state_nx = S_SCAN;
      S_SCAN: if (publish && (CONTINUOUS == 0)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // cnt[1:0] selects the probe kind, cnt>>2 the character during issue
  always_comb begin
    s_left = '0; s_right = '0; s_top = '0; s_bottom = '0; s_dy = '0; s_dx = '0;
    for (int c = 0; c < NUM_CHARS; c++) begin
      if ((cnt >> 2) == CW'(c)) begin
        s_left   = l_left[10*c +: 10];
        s_right  = l_right[10*c +: 10];
        s_top    = l_top[10*c +: 10];
        s_bottom = l_bottom[10*c +: 10];
        s_dy     = l_dy[10*c +: 10];
        s_dx     = l_dx[10*c +: 10];
      end
    end
    xl = clamp_x({1'b0, s_left});
    xr = clamp_x({1'b0, s_right});
    xm = clamp_x({1'b0, s_left} + {1'b0, s_dx});
    ys = clamp_y((s_bottom < s_dy) ? 10'd0 : s_bottom - s_dy);
    yt = ({1'b0, s_top} >= 11'(SCREEN_H)) ? 10'd0 : s_top;
    yb = clamp_y(s_bottom);
    case (cnt[1:0])
      2'd0:    begin x = xl; y = ys; end
      2'd1:    begin x = xr; y = ys; end
      2'd2:    begin x = xm; y = yt; end
      default: begin x = xm; y = yb; end
    endcase
    addr_w = 19'(20'(x) + 20'(y) * 20'(SCREEN_W));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      rom_addr   <= '0;
      scan_done  <= 1'b0;
      hit_left   <= '0;
      hit_right  <= '0;
      hit_top    <= '0;
      hit_bottom <= '0;
      l_left     <= '0;
      l_right    <= '0;
      l_top      <= '0;
      l_bottom   <= '0;
      l_dy       <= '0;
      l_dx       <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        tag_v[s] <= 1'b0;
        tag_p[s] <= '0;
      end
      for (int q = 0; q < P; q++) shadow[q] <= '0;
    end else begin
      scan_done <= publish;
      if (relatch) begin
        l_left   <= char_left;
        l_right  <= char_right;
        l_top    <= char_top;
        l_bottom <= char_bottom;
        l_dy     <= side_dy;
        l_dx     <= mid_dx;
        cnt      <= '0;
      end else if (state == S_SCAN) begin
        cnt <= cnt + CW'(1);
      end
      if (issue) rom_addr <= addr_w;
      // tag pipeline tracks which shadow slot the returning rom_data belongs to
      tag_v[0] <= issue;
      tag_p[0] <= cnt[PW-1:0];
      for (int s = 1; s < ROM_LATENCY; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_p[s] <= tag_p[s-1];
      end
      if (tag_v[ROM_LATENCY-1]) shadow[tag_p[ROM_LATENCY-1]] <= rom_data;
      if (publish) begin
        for (int c = 0; c < NUM_CHARS; c++) begin
          hit_left[c*DATA_W +: DATA_W]   <= shadow[4*c];
          hit_right[c*DATA_W +: DATA_W]  <= shadow[4*c+1];
          hit_top[c*DATA_W +: DATA_W]    <= shadow[4*c+2];
          hit_bottom[c*DATA_W +: DATA_W] <= shadow[4*c+3];
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_probe_scanner.sv
// tb/tb_collision_probe_scanner.sv - directed bench for collision_probe_scanner
module tb_collision_probe_scanner;

  logic vga_clk;
  logic rst_n, rst1_n;
  logic start0, start1, start2;
  logic [19:0] cl, cr, ct, cb, cdy, cdx;
  logic [39:0] ql, qr, qt, qb, qdy, qdx;

  logic [18:0] rom_addr0, rom_addr1, rom_addr2;
  logic [2:0]  rom_data0, rom_data1, rom_data2;
  logic [5:0]  hl0, hr0, ht0, hb0, hl1, hr1, ht1, hb1;
  logic [11:0] hl2, hr2, ht2, hb2;
  logic busy0, busy1, busy2, done0, done1, done2;

  int total = 0;
  int bad   = 0;

  collision_probe_scanner dut0 (
    .vga_clk(vga_clk), .reset_n(rst_n), .start(start0),
    .char_left(cl), .char_right(cr), .char_top(ct), .char_bottom(cb),
    .side_dy(cdy), .mid_dx(cdx), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .hit_left(hl0), .hit_right(hr0), .hit_top(ht0), .hit_bottom(hb0),
    .busy(busy0), .scan_done(done0));

  collision_probe_scanner #(.ROM_LATENCY(1), .CONTINUOUS(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(rst1_n), .start(start1),
    .char_left(cl), .char_right(cr), .char_top(ct), .char_bottom(cb),
    .side_dy(cdy), .mid_dx(cdx), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .hit_left(hl1), .hit_right(hr1), .hit_top(ht1), .hit_bottom(hb1),
    .busy(busy1), .scan_done(done1));

  collision_probe_scanner #(.NUM_CHARS(4), .ROM_LATENCY(7)) dut2 (
    .vga_clk(vga_clk), .reset_n(rst_n), .start(start2),
    .char_left(ql), .char_right(qr), .char_top(qt), .char_bottom(qb),
    .side_dy(qdy), .mid_dx(qdx), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .hit_left(hl2), .hit_right(hr2), .hit_top(ht2), .hit_bottom(hb2),
    .busy(busy2), .scan_done(done2));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // ROM models: data = low 3 address bits, ROM_LATENCY edges after the address update
  logic [2:0] d0_1, d0_2;
  logic [2:0] d2 [1:6];
  always @(posedge vga_clk) begin
    d0_1 <= rom_addr0[2:0];
    d0_2 <= d0_1;
    d2[1] <= rom_addr2[2:0];
    for (int j = 2; j <= 6; j++) d2[j] <= d2[j-1];
  end
  assign rom_data0 = d0_2;
  assign rom_data1 = rom_addr1[2:0];
  assign rom_data2 = d2[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_char(input int i, input int l, input int r, input int t,
                          input int b, input int dy, input int dx);
    cl[10*i +: 10]  = 10'(l);
    cr[10*i +: 10]  = 10'(r);
    ct[10*i +: 10]  = 10'(t);
    cb[10*i +: 10]  = 10'(b);
    cdy[10*i +: 10] = 10'(dy);
    cdx[10*i +: 10] = 10'(dx);
  endtask

  initial begin
    int ea [8];
    int eb [8];
    int ec [4];
    int done_cnt;

    rst_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    cl = '0; cr = '0; ct = '0; cb = '0; cdy = '0; cdx = '0;
    ql = '0; qr = '0; qt = '0; qb = '0; qdy = '0; qdx = '0;
    repeat (2) @(negedge vga_clk);

    chk("reset_addr", 32'(rom_addr0), 32'd0);
    chk("reset_hit",  32'(hl0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_busy_cont", 32'(busy1), 32'd0);

    // defaults: per-slot results and publish timing
    rst_n = 1'b1;
    set_char(0, 100, 130, 200, 230, 15, 13);
    set_char(1, 301, 331, 100, 140, 25, 25);
    ea = '{137700, 137730, 128113, 147313, 73901, 73931, 64326, 89926};
    @(negedge vga_clk);
    chk("idle_no_start", 32'(busy0), 32'd0);
    start0 = 1'b1;
    @(negedge vga_clk);
    start0 = 1'b0;
    chk("busy_after_start", 32'(busy0), 32'd1);
    for (int n = 1; n <= 13; n++) begin
      @(negedge vga_clk);
      if (n <= 8) chk($sformatf("addr_p%0d", n-1), 32'(rom_addr0), 32'(ea[n-1]));
      if (n < 12) begin
        chk($sformatf("no_done_%0d", n), 32'(done0), 32'd0);
        chk($sformatf("hit_held_%0d", n), 32'(hl0), 32'd0);
      end
      if (n == 12) begin
        chk("done_pulse", 32'(done0), 32'd1);
        chk("busy_fall", 32'(busy0), 32'd0);
        chk("hit_left", 32'(hl0), 32'd44);
        chk("hit_right", 32'(hr0), 32'd26);
        chk("hit_top", 32'(ht0), 32'd49);
        chk("hit_bottom", 32'(hb0), 32'd49);
      end
      if (n == 13) begin
        chk("done_one_cycle", 32'(done0), 32'd0);
        chk("addr_hold", 32'(rom_addr0), 32'd89926);
      end
    end

    // clamps/underflow, plus input changes and start pulse during a scan
    set_char(0, 630, 639, 0, 0, 15, 25);
    set_char(1, 5, 20, 1020, 10, 25, 25);
    eb = '{630, 639, 639, 639, 5, 20, 30, 6430};
    done_cnt = 0;
    start0 = 1'b1;
    @(negedge vga_clk);
    start0 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge vga_clk);
      if (n <= 8) chk($sformatf("clamp_addr_p%0d", n-1), 32'(rom_addr0), 32'(eb[n-1]));
      if (n == 2) begin
        cl = '0; cr = '0; ct = '0; cb = '0; cdy = '0; cdx = '0;
      end
      if (n == 3) start0 = 1'b1;
      if (n == 4) start0 = 1'b0;
      if (done0) done_cnt++;
      if (n == 12) begin
        chk("clamp_hit_left", 32'(hl0), 32'd46);
        chk("clamp_hit_right", 32'(hr0), 32'd39);
        chk("clamp_hit_top", 32'(ht0), 32'd55);
        chk("clamp_hit_bottom", 32'(hb0), 32'd55);
      end
    end
    chk("single_done", 32'(done_cnt), 32'd1);
    chk("idle_after_ignored_start", 32'(busy0), 32'd0);
    chk("addr_hold_after", 32'(rom_addr0), 32'd6430);

    // continuous mode, latency 1
    set_char(0, 100, 130, 200, 230, 15, 13);
    set_char(1, 301, 331, 100, 140, 25, 25);
    rst1_n = 1'b1;
    @(negedge vga_clk);
    chk("cont_busy_start", 32'(busy1), 32'd1);
    for (int n = 1; n <= 35; n++) begin
      @(negedge vga_clk);
      chk($sformatf("cont_busy_%0d", n), 32'(busy1), 32'd1);
      chk($sformatf("cont_done_%0d", n), 32'(done1), 32'(n % 10 == 0));
      if (n == 1 || n == 11) chk($sformatf("cont_addr_%0d", n), 32'(rom_addr1), 32'd137700);
      if (n == 10) chk("cont_hit_left", 32'(hl1), 32'd44);
    end
    #2 rst1_n = 1'b0;
    #1;
    chk("async_addr", 32'(rom_addr1), 32'd0);
    chk("async_busy", 32'(busy1), 32'd0);
    chk("async_done", 32'(done1), 32'd0);
    chk("async_hit", 32'(hl1), 32'd0);
    repeat (3) begin
      @(negedge vga_clk);
      chk("held_in_reset", 32'(busy1), 32'd0);
    end
    rst1_n = 1'b1;
    @(negedge vga_clk);
    chk("cont_resume", 32'(busy1), 32'd1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge vga_clk);
      chk($sformatf("resume_done_%0d", n), 32'(done1), 32'(n == 10));
    end

    // four characters, latency 7
    ql[30 +: 10] = 10'd203; qr[30 +: 10] = 10'd222; qt[30 +: 10] = 10'd50;
    qb[30 +: 10] = 10'd90;  qdy[30 +: 10] = 10'd15; qdx[30 +: 10] = 10'd14;
    ec = '{48203, 48222, 32217, 57817};
    start2 = 1'b1;
    @(negedge vga_clk);
    start2 = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge vga_clk);
      if (n <= 12) chk($sformatf("n4_addr_p%0d", n-1), 32'(rom_addr2), 32'd0);
      else if (n <= 16) chk($sformatf("n4_addr_p%0d", n-1), 32'(rom_addr2), 32'(ec[n-13]));
      chk($sformatf("n4_done_%0d", n), 32'(done2), 32'(n == 24));
      if (n == 23) chk("n4_hit_held", 32'(hl2), 32'd0);
      if (n == 24) begin
        chk("n4_hit_left", 32'(hl2), 32'd1536);
        chk("n4_hit_right", 32'(hr2), 32'd3072);
        chk("n4_hit_top", 32'(ht2), 32'd512);
        chk("n4_hit_bottom", 32'(hb2), 32'd512);
      end
      if (n == 25) chk("n4_idle", 32'(busy2), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collision_probe_scanner.md
Name: collision_probe_scanner

Overview:
- Parametrised successor to the two-character collision probe sequencer.
- Scans the full-screen collision ROM at four probe points (left, right, top, bottom) for each of NUM_CHARS characters.
- Probe offsets are run-time inputs; probe addresses are issued one per clock, pipelined against a configurable ROM read latency.
- Results are published atomically once per scan, so game logic never sees a half-updated set. Triggered or free-running mode.

Parameters:
NUM_CHARS, 2, number of characters scanned (index 0 = fireboy, 1 = watergirl)
ROM_LATENCY, 3, vga_clk posedges from rom_addr update to valid rom_data (min 1, max 7)
SCREEN_W, 640, collision map width in pixels
SCREEN_H, 480, collision map height in pixels
DATA_W, 3, collision ROM data width
CONTINUOUS, 0, 1 = restart automatically after each scan; 0 = scan only on start

Ports:
vga_clk  in  1  clock; all state on posedge
reset_n  in  1  asynchronous, active-low reset
start  in  1  request one scan; sampled only when busy=0
char_left  in  NUM_CHARS*10  per-char left x (char i at bits [10i+9:10i]; same packing for all per-char buses)
char_right  in  NUM_CHARS*10  per-char right x
char_top  in  NUM_CHARS*10  per-char top y (may be wrapped-negative)
char_bottom  in  NUM_CHARS*10  per-char bottom y
side_dy  in  NUM_CHARS*10  side-probe rise above bottom (fireboy 15, watergirl 25)
mid_dx  in  NUM_CHARS*10  top/bottom probe x offset from left (fireboy 13, watergirl 25)
rom_addr  out  19  collision ROM address
rom_data  in  DATA_W  collision ROM read data
hit_left, hit_right, hit_top, hit_bottom  out  NUM_CHARS*DATA_W each  published probe results
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse when results are published

Behaviour:
- Reset (async assert, sync release): rom_addr=0, all hit_* = 0, busy=0, scan_done=0, internal shadow results and tag pipeline cleared. Reset mid-scan discards the scan. No scan_done pulse. Published results stay 0.
- Start: at edge k with busy=0 and (start=1, or CONTINUOUS=1 and not in reset), all coordinate and offset inputs are latched and busy<=1. Input changes during a scan have no effect.
- Probe order: p = 4i + {0:L, 1:R, 2:T, 3:B} for char i; P = 4*NUM_CHARS probes.
- Issue: at edges k+1 .. k+P, rom_addr <= addr(p) for p = 0..P-1. rom_addr holds its last value afterwards.
- Sample: rom_data for probe p is written into shadow slot p at edge k+1+p+ROM_LATENCY. Implementation is a ROM_LATENCY-deep shift register of {valid, p}.
- Publish: at edge k+P+ROM_LATENCY+1, the shadow is copied to hit_* and scan_done pulses high for exactly 1 cycle.
  - CONTINUOUS=0: busy<=0 at the same edge.
  - CONTINUOUS=1: busy stays 1 and this edge acts as the next scan's edge k (relatch, restart).
- start while busy=1 is ignored, not queued.
- Address arithmetic, for latched char i:
  - ys = bottom - side_dy; ys = 0 if bottom < side_dy.
  - yt = top; yt = 0 if top >= SCREEN_H (wrapped negative).
  - xm = left + mid_dx, computed 11-bit.
  - Every x clamps to SCREEN_W-1 and every y to SCREEN_H-1.
  - L = left + ys*SCREEN_W
  - R = right + ys*SCREEN_W
  - T = xm + yt*SCREEN_W
  - B = xm + bottom*SCREEN_W
  - Computed at least 20 bits wide, then truncated to 19. Maximum is 307199, which never overflows.
- Scan length: P + ROM_LATENCY + 1 cycles; 12 cycles for the defaults.

Test Plan:
1. Defaults. Char0: left=100, right=130, top=200, bottom=230, dy=15, dx=13; start at edge k.
   - rom_addr = 137700, 137730, 128113, 147313 at edges k+1..k+4.
   - scan_done at k+12; busy falls at k+12.
2. ROM model returns addr[2:0] after 3 cycles, fixed char0/char1 coordinates.
   - hit_* equal the low 3 bits of each probe address, in the correct per-char slots.
   - hit_* do not change before scan_done.
3. Underflow. Char1: top=1020, bottom=10, side_dy=25, left=5, mid_dx=25.
   - T address = 30; L address = 5 (y clamped to 0).
   - left=630, mid_dx=25 gives xm clamped to 639.
4. Change inputs and pulse start mid-scan.
   - Addresses still reflect the latched values; the second start is ignored.
   - Exactly one scan_done.
5. CONTINUOUS=1, ROM_LATENCY=1.
   - scan_done every 10 cycles and busy never drops.
   - Reset_n asserted at cycle 5 of a scan: all outputs 0 immediately; scanning resumes only after release.
6. NUM_CHARS=4, ROM_LATENCY=7.
   - 16 addresses issued on consecutive edges; scan_done 24 cycles after start.
   - Char3 results land in bits [11:9] of each hit_* bus.
